// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: sequences the shared multi-cycle mult/div units and owns
// the HI/LO writeback strobe. A one-cycle start from the control unit becomes
// an init pulse, a fixed-length run and a single hl_load/done cycle.
// A divide-by-zero is caught before the divider is ever started.
//
// Optional build macro: MULDIV_BACK2BACK_EN. When defined, a start arriving
// during the WRITE cycle is accepted directly, so back-to-back ops skip IDLE.
//
// Handshake: start_mult/start_div are single-cycle requests sampled only
// while the sequencer can accept them (IDLE, plus WRITE with the macro).
// There is no ready signal. The control unit must hold off while busy is
// high, and any request made while busy outside the accept window is dropped.
// Every output is a flop (Moore). state_dbg mirrors the FSM state.
module muldiv_sequencer #(
   parameter int MULT_CYCLES = 32,
   parameter int DIV_CYCLES  = 32,
   parameter int CNT_W       = 6
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start_mult,
   input  logic        start_div,
   input  logic        div_src_mdr,
   input  logic [31:0] divisor,
   input  logic        flush,
   output logic        mult_init,
   output logic        div_init,
   output logic        div_src_sel,
   output logic        hilo_sel,
   output logic        hl_load,
   output logic        busy,
   output logic        done,
   output logic        div_zero,
   output logic [2:0]  state_dbg
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      MULT_RUN = 3'd1,
      DIV_RUN  = 3'd2,
      WRITE    = 3'd3,
      DZ       = 3'd4
   } state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             hilo_sel_nxt;
   logic             div_src_sel_nxt;
   logic             start_window;

`ifdef MULDIV_BACK2BACK_EN
   assign start_window = (state == IDLE) || (state == WRITE);
`else
   assign start_window = (state == IDLE);
`endif

   assign state_dbg = state;

   // Next-state, run counter and held selector values.
   always_comb begin
      state_nxt       = state;
      cnt_nxt         = cnt;
      hilo_sel_nxt    = hilo_sel;
      div_src_sel_nxt = div_src_sel;
      if (flush && (state != IDLE)) begin
         // Abort outranks both counter expiry and any start in this cycle.
         state_nxt = IDLE;
      end else begin
         case (state)
            MULT_RUN, DIV_RUN: begin
               if (cnt == '0) begin
                  state_nxt = WRITE;
               end else begin
                  cnt_nxt = cnt - 1'b1;
               end
            end
            WRITE, DZ: state_nxt = IDLE;
            default:   state_nxt = IDLE;
         endcase
         if (start_window) begin
            // Mult wins a simultaneous request; the div request is dropped.
            if (start_mult) begin
               state_nxt    = MULT_RUN;
               cnt_nxt      = CNT_W'(MULT_CYCLES - 1);
               hilo_sel_nxt = 1'b1;
            end else if (start_div) begin
               if (divisor == '0) begin
                  state_nxt = DZ;
               end else begin
                  state_nxt       = DIV_RUN;
                  cnt_nxt         = CNT_W'(DIV_CYCLES - 1);
                  hilo_sel_nxt    = 1'b0;
                  div_src_sel_nxt = div_src_mdr;
               end
            end
         end
      end
   end

   // State, counter and registered outputs decoded from the next state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         cnt         <= '0;
         mult_init   <= 1'b0;
         div_init    <= 1'b0;
         div_src_sel <= 1'b0;
         hilo_sel    <= 1'b0;
         hl_load     <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         div_zero    <= 1'b0;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         mult_init   <= (state_nxt == MULT_RUN) && (state != MULT_RUN);
         div_init    <= (state_nxt == DIV_RUN) && (state != DIV_RUN);
         div_src_sel <= div_src_sel_nxt;
         hilo_sel    <= hilo_sel_nxt;
         hl_load     <= (state_nxt == WRITE);
         done        <= (state_nxt == WRITE);
         busy        <= (state_nxt != IDLE);
         div_zero    <= (state_nxt == DZ);
      end
   end

endmodule
